ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Serial configuration-chain loader for an OpenFPGA tile column. Accepts bitstream words over a valid/ready interface and serialises them MSB-first onto `ccff_head` with a per-bit shift enable. The shift enable drives an external clock gate, so the chain's flip-flops only advance on real data bits. It counts exactly `CHAIN_LEN` bits, then asserts `cfg_done` to release the IO tiles' pads; words may stall without corrupting the chain, and an abort path is provided.

## Interface
- `CHAIN_LEN`, default 64: total configuration bits in the downstream chain. Legal range is 1 to 65535.
- `WORD_W`, default 8: bitstream word width. Legal range is 1 to 32.
- `prog_clk` input, 1 bit: configuration clock. This is the only clock in the block.
- `prog_reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: one-cycle pulse that begins a load. Sampled only in IDLE or DONE.
- `abort` input, 1 bit: terminates the load in progress. Has priority over all other inputs except reset.
- `word_valid` input, 1 bit: `word_data` is valid this cycle.
- `word_data` input, `WORD_W` bits: bitstream word. Bit `[WORD_W-1]` is shifted first.
- `word_ready` output, 1 bit: loader accepts the word this cycle.
- `ccff_head` output, 1 bit: serial data into the first chain stage. Registered.
- `ccff_shift_en` output, 1 bit: chain clock-gate enable. Registered and aligned with `ccff_head`.
- `ccff_tail` input, 1 bit: end of chain. Its value is captured into `tail_bit` at the final shift.
- `tail_bit` output, 1 bit: value of `ccff_tail` sampled on the last shift cycle. Used for chain-continuity debug.
- `cfg_done` output, 1 bit: configuration complete. Drives the tiles' `cfg_done`.
- `busy` output, 1 bit: high in LOAD.
- `aborted` output, 1 bit: sticky flag indicating the last load was aborted. Cleared by `start`.

## Operation
- **States:** IDLE, LOAD, DONE.
- **Reset values:** state is IDLE. `ccff_head`, `ccff_shift_en`, `word_ready`, `cfg_done`, `busy`, `aborted` and `tail_bit` are all 0. The bit counter, word buffer and buffer count are 0.
- **IDLE or DONE with `start`=1:**
  - Next state is LOAD.
  - `bits_left` is loaded with `CHAIN_LEN`. Its width is `clog2(CHAIN_LEN+1)`.
  - The buffer is emptied; `cfg_done`, `aborted` and `tail_bit` are cleared.
- **Buffer:** one `WORD_W`-bit shift register plus `buf_cnt` (range 0 to `WORD_W`).
- **`word_ready`:** equals (state==LOAD) AND (`buf_cnt`==0 OR (`buf_cnt`==1 AND a bit is being emitted this cycle)) AND `bits_left` > `buf_cnt`. This is combinational from registered state.
- **Accept:** on `word_valid` AND `word_ready`, the buffer loads `word_data` and `buf_cnt` becomes `WORD_W`.
- **Emit, LOAD with `buf_cnt` > 0:**
  - Next cycle, `ccff_head` = buffer MSB and `ccff_shift_en` = 1.
  - The buffer shifts left by 1; `buf_cnt` and `bits_left` each decrement by 1.
- **Stall, LOAD with `buf_cnt` == 0:** next cycle `ccff_shift_en` = 0 and `ccff_head` holds its value. The chain does not advance.
- **Last bit emitted (`bits_left` 1 to 0):**
  - Next state is DONE.
  - `tail_bit` <= `ccff_tail` on the cycle the last bit is presented, i.e. while `ccff_shift_en`=1 with the final bit.
  - `cfg_done` = 1 in the first DONE cycle and holds until `start` or reset.
- **Partial last word:** when `CHAIN_LEN` mod `WORD_W` = r ≠ 0, only the top r bits of the final word are emitted and the low bits are discarded. No extra word is requested once `bits_left` ≤ `buf_cnt`.
- **`abort` in LOAD:**
  - Next state is IDLE; `aborted` = 1.
  - `ccff_shift_en` = 0 next cycle; `cfg_done` stays 0; the buffer is cleared.
  - A word offered on the same cycle is not accepted (`word_ready` is forced to 0).
- **`abort` outside LOAD:** no effect.
- **`start` during LOAD:** ignored.
- **`start` and `abort` on the same cycle in DONE:** `start` wins, because `abort` is a no-op outside LOAD.
- **Reset mid-load:** all outputs return to reset values immediately (asynchronous). The chain contents are undefined, and software must reload.

## Timing
- `start` at cycle 0 gives LOAD at cycle 1, where `word_ready` = 1.
- A word accepted at cycle n has its first bit on `ccff_head` with `ccff_shift_en`=1 at cycle n+1.
- With `word_valid` held high, bits stream gaplessly: one bit per cycle, with no bubble between words.
- Total load time with no stalls is `CHAIN_LEN` shift cycles plus 1 (start) plus 1 (DONE entry).
- `cfg_done` rises exactly one cycle after the last `ccff_shift_en`=1 cycle.
- All outputs are glitch-free registers except `word_ready`.

## Test plan
- **Gapless stream:** `CHAIN_LEN`=16, `WORD_W`=8, words 0xA5 then 0x3C with valid always high. Require `ccff_head` over 16 consecutive shift-enabled cycles = 1010010100111100, `ccff_shift_en` never drops, `cfg_done`=1 on the following cycle, and `word_ready` never high a third time.
- **Partial word:** `CHAIN_LEN`=20, `WORD_W`=8, words 0xFF, 0x00, 0xF3. Require exactly 20 shifts ending with bits 1111, exactly 3 words accepted, and `cfg_done`=1.
- **Stall:** as the gapless stream, but `word_valid` is low for 5 cycles between the words. Require `ccff_shift_en`=0 for exactly those 5 cycles, `ccff_head` held, and the bit sequence unchanged.
- **Abort:** assert `abort` after 5 shifts. Require IDLE next cycle, `aborted`=1, `cfg_done`=0, and no further `ccff_shift_en`. Then a new `start` clears `aborted` and a full reload completes with `cfg_done`=1.
- **Tail capture:** model the chain as a 16-stage shift register clocked when `ccff_shift_en`=1, preloaded with 0x8000. Require `tail_bit`=1 after load. With a preload of 0x0000, require `tail_bit`=0.
- **Async reset mid-load:** pulse `prog_reset` between clock edges at bit 9. Require all outputs 0 immediately without waiting for a clock edge, state IDLE, and `start` ignored until reset deasserts.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Serial configuration-chain loader for an OpenFPGA tile column.
//
// Accepts bitstream words over a valid/ready handshake and shifts them MSB-first
// onto the configuration chain. The chain clock gate is enabled only on real
// data bits. Exactly CHAIN_LEN bits are shifted, then cfg_done is raised.
//
// Ports:
//   prog_clk, prog_reset       configuration clock, async active-high reset
//   start                      pulse: begin a load (sampled in IDLE/DONE)
//   abort                      terminate the load in progress
//   word_valid/word_data       bitstream word in; bit [WORD_W-1] goes first
//   word_ready                 word accepted this cycle (combinational)
//   ccff_head, ccff_shift_en   registered serial data and chain shift enable
//   ccff_tail, tail_bit        chain output, captured on the final shift
//   cfg_done, busy, aborted    status flags
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              tail_bit,
    output logic              cfg_done,
    output logic              busy,
    output logic              aborted
);

    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BUF_CNT_W = $clog2(WORD_W + 1);
    localparam int unsigned CMP_W     = (CNT_W > BUF_CNT_W) ? CNT_W : BUF_CNT_W;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bits_left_q, bits_left_d;
    logic [WORD_W-1:0]    buf_q, buf_d;
    logic [BUF_CNT_W-1:0] buf_cnt_q, buf_cnt_d;
    logic                 head_q, head_d;
    logic                 shift_en_q, shift_en_d;
    logic                 last_q, last_d;     // current shift carries the final bit
    logic                 tail_q, tail_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 busy_q, busy_d;

    logic buf_empty;
    logic accept;
    logic emit;

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        buf_d       = buf_q;
        buf_cnt_d   = buf_cnt_q;
        head_d      = head_q;
        shift_en_d  = 1'b0;
        last_d      = 1'b0;
        done_d      = done_q;
        aborted_d   = aborted_q;
        busy_d      = busy_q;
        word_ready  = 1'b0;
        accept      = 1'b0;
        emit        = 1'b0;
        buf_empty   = (buf_cnt_q == '0);
        // The chain presents its tail while the final bit is being shifted in.
        tail_d      = last_q ? ccff_tail : tail_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    done_d = 1'b1;
                end
                if (start) begin
                    state_d     = StLoad;
                    bits_left_d = CNT_W'(CHAIN_LEN);
                    buf_d       = '0;
                    buf_cnt_d   = '0;
                    done_d      = 1'b0;
                    aborted_d   = 1'b0;
                    tail_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d     = StIdle;
                    aborted_d   = 1'b1;
                    busy_d      = 1'b0;
                    bits_left_d = '0;
                    buf_d       = '0;
                    buf_cnt_d   = '0;
                end else begin
                    // Refill on empty, or while the last buffered bit goes out, but never
                    // request a word once the buffer already covers the remaining bits.
                    word_ready = (buf_empty || (buf_cnt_q == BUF_CNT_W'(1)))
                                 && (CMP_W'(bits_left_q) > CMP_W'(buf_cnt_q));
                    accept     = word_valid && word_ready;
                    emit       = !buf_empty || accept;

                    if (!buf_empty) begin
                        head_d    = buf_q[WORD_W-1];
                        buf_d     = buf_q << 1;
                        buf_cnt_d = buf_cnt_q - BUF_CNT_W'(1);
                    end else if (accept) begin
                        // Bypass: first bit of a word into an empty buffer goes out at once.
                        head_d    = word_data[WORD_W-1];
                        buf_d     = word_data << 1;
                        buf_cnt_d = BUF_CNT_W'(WORD_W - 1);
                    end
                    if (!buf_empty && accept) begin
                        buf_d     = word_data;
                        buf_cnt_d = BUF_CNT_W'(WORD_W);
                    end

                    if (emit) begin
                        shift_en_d  = 1'b1;
                        bits_left_d = bits_left_q - CNT_W'(1);
                        if (bits_left_q == CNT_W'(1)) begin
                            // Leftover low bits of a partial final word are dropped.
                            state_d   = StDone;
                            busy_d    = 1'b0;
                            last_d    = 1'b1;
                            buf_d     = '0;
                            buf_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= StIdle;
            bits_left_q <= '0;
            buf_q       <= '0;
            buf_cnt_q   <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            last_q      <= 1'b0;
            tail_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            buf_q       <= buf_d;
            buf_cnt_q   <= buf_cnt_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            last_q      <= last_d;
            tail_q      <= tail_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            busy_q      <= busy_d;
        end
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign tail_bit      = tail_q;
    assign cfg_done      = done_q;
    assign busy          = busy_q;
    assign aborted       = aborted_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 16-bit and a 20-bit chain instance
// share all inputs; the 16-bit instance drives a modelled chain for tail capture.
module tb_ccff_chain_loader;

    logic       prog_clk;
    logic       prog_reset;
    logic       start;
    logic       abort;
    logic       word_valid;
    logic [7:0] word_data;
    logic       ccff_tail;

    logic word_ready16, ccff_head16, ccff_shift_en16, tail_bit16, cfg_done16, busy16, aborted16;
    logic word_ready20, ccff_head20, ccff_shift_en20, tail_bit20, cfg_done20, busy20, aborted20;

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .abort         (abort),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_ready    (word_ready16),
        .ccff_head     (ccff_head16),
        .ccff_shift_en (ccff_shift_en16),
        .ccff_tail     (ccff_tail),
        .tail_bit      (tail_bit16),
        .cfg_done      (cfg_done16),
        .busy          (busy16),
        .aborted       (aborted16)
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .abort         (abort),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_ready    (word_ready20),
        .ccff_head     (ccff_head20),
        .ccff_shift_en (ccff_shift_en20),
        .ccff_tail     (ccff_tail),
        .tail_bit      (tail_bit20),
        .cfg_done      (cfg_done20),
        .busy          (busy20),
        .aborted       (aborted20)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // 16-stage chain model: head enters bit 15, tail is bit 0.
    logic [15:0] chain;
    assign ccff_tail = chain[0];

    int          n_cmp;
    int          n_err;
    int          cyc;
    logic [31:0] seq16, seq20;
    int          nsh16, nsh20, gap16, head_moved, rdy16, acc20;
    int          last_sh16, done_cyc;
    bit          done_seen;
    logic        last_head16;
    bit          acc_now;
    bit          sel20;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        cyc        = 0;
        seq16      = '0;
        seq20      = '0;
        nsh16      = 0;
        nsh20      = 0;
        gap16      = 0;
        head_moved = 0;
        rdy16      = 0;
        acc20      = 0;
        last_sh16  = -1;
        done_cyc   = -1;
        done_seen  = 1'b0;
    endtask

    // One clock cycle: sample at negedge, advance past posedge, update chain model.
    task automatic step();
        logic en16;
        logic h16;
        @(negedge prog_clk);
        en16 = ccff_shift_en16;
        h16  = ccff_head16;
        if (en16) begin
            seq16     = {seq16[30:0], h16};
            nsh16++;
            last_sh16 = cyc;
        end else if (busy16 && nsh16 > 0) begin
            gap16++;
            if (h16 !== last_head16) head_moved++;
        end
        last_head16 = h16;
        if (ccff_shift_en20) begin
            seq20 = {seq20[30:0], ccff_head20};
            nsh20++;
        end
        if (word_ready16) rdy16++;
        if (word_valid && word_ready20) acc20++;
        if (cfg_done16 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        acc_now = word_valid && (sel20 ? word_ready20 : word_ready16);
        @(posedge prog_clk);
        #1;
        if (en16) chain = {h16, chain[15:1]};
        cyc++;
    endtask

    // Abort pulse first so an instance left waiting for words returns to IDLE.
    task automatic do_start();
        abort = 1'b1;
        step();
        abort = 1'b0;
        mon_clear();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Feed n words with valid held high; optional stall after the first word.
    task automatic load(input int n, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input int stall);
        logic [7:0] ws [3];
        int         k;
        ws[0] = w0;
        ws[1] = w1;
        ws[2] = w2;
        k = 0;
        word_data  = ws[0];
        word_valid = 1'b1;
        for (int i = 0; i < 200 && k < n; i++) begin
            step();
            if (acc_now) begin
                k++;
                if (k < n) begin
                    word_data = ws[k];
                    if (stall > 0 && k == 1) begin
                        word_valid = 1'b0;
                        repeat (stall) step();
                        word_valid = 1'b1;
                    end
                end else begin
                    word_valid = 1'b0;
                end
            end
        end
        check_eq("words_taken", k, n);
        for (int i = 0; i < 100 && !(sel20 ? cfg_done20 : cfg_done16); i++) step();
        step();
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        start      = 1'b0;
        abort      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        sel20      = 1'b0;
        chain      = '0;
        last_head16 = 1'b0;
        mon_clear();
        prog_reset = 1'b0;
        #1 prog_reset = 1'b1;
        #11;
        check_eq("reset_outs16", {ccff_head16, ccff_shift_en16, word_ready16, cfg_done16,
                                  busy16, aborted16, tail_bit16}, 7'd0);
        check_eq("reset_outs20", {ccff_head20, ccff_shift_en20, word_ready20, cfg_done20,
                                  busy20, aborted20, tail_bit20}, 7'd0);
        @(posedge prog_clk);
        #1 prog_reset = 1'b0;
        step();

        // Gapless stream, chain preloaded with 0x8000.
        chain = 16'h8000;
        do_start();
        check_eq("load_ready", {busy16, word_ready16}, 2'b11);
        load(2, 8'hA5, 8'h3C, 8'h00, 0);
        check_eq("gapless_seq", seq16[15:0], 16'hA53C);
        check_eq("gapless_nshift", nsh16, 16);
        check_eq("gapless_gaps", gap16, 0);
        check_eq("gapless_ready_cycles", rdy16, 2);
        check_eq("gapless_done_lat", done_cyc - last_sh16, 1);
        check_eq("gapless_done_cycle", done_cyc, 18);
        check_eq("tail_one", tail_bit16, 1'b1);

        // Tail capture with an all-zero chain.
        chain = 16'h0000;
        do_start();
        load(2, 8'hA5, 8'h3C, 8'h00, 0);
        check_eq("tail_zero_done", cfg_done16, 1'b1);
        check_eq("tail_zero", tail_bit16, 1'b0);

        // start and abort together in DONE: start wins.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_abort_done", {busy16, aborted16, cfg_done16}, 3'b100);

        // Stall of five cycles between the two words.
        do_start();
        load(2, 8'hA5, 8'h3C, 8'h00, 12);
        check_eq("stall_gaps", gap16, 5);
        check_eq("stall_head_held", head_moved, 0);
        check_eq("stall_seq", seq16[15:0], 16'hA53C);
        check_eq("stall_done", cfg_done16, 1'b1);

        // Partial last word on the 20-bit chain.
        sel20 = 1'b1;
        do_start();
        load(3, 8'hFF, 8'h00, 8'hF3, 0);
        check_eq("partial_nshift", nsh20, 20);
        check_eq("partial_seq", seq20[19:0], 20'hFF00F);
        check_eq("partial_last4", seq20[3:0], 4'hF);
        check_eq("partial_words", acc20, 3);
        check_eq("partial_done", cfg_done20, 1'b1);
        sel20 = 1'b0;

        // Abort after five shifts.
        do_start();
        word_valid = 1'b1;
        word_data  = 8'hA5;
        for (int i = 0; i < 50 && nsh16 < 5; i++) begin
            step();
            if (acc_now) word_data = 8'h3C;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_state", {busy16, aborted16, cfg_done16, ccff_shift_en16}, 4'b0100);
        begin
            int n_before;
            n_before = nsh16;
            repeat (10) step();
            check_eq("abort_no_shift", nsh16, n_before);
            check_eq("abort_no_ready", word_ready16, 1'b0);
        end
        word_valid = 1'b0;
        do_start();
        check_eq("restart_clears_abort", {busy16, aborted16}, 2'b10);
        load(2, 8'hA5, 8'h3C, 8'h00, 0);
        check_eq("reload_seq", seq16[15:0], 16'hA53C);
        check_eq("reload_done", cfg_done16, 1'b1);

        // Asynchronous reset in the middle of a load.
        do_start();
        word_valid = 1'b1;
        word_data  = 8'hA5;
        for (int i = 0; i < 50 && nsh16 < 9; i++) begin
            step();
            if (acc_now) word_data = 8'h3C;
        end
        check_eq("pre_reset_busy", {busy16, ccff_shift_en16}, 2'b11);
        #2 prog_reset = 1'b1;
        #1;
        check_eq("async_reset_outs", {ccff_head16, ccff_shift_en16, word_ready16, cfg_done16,
                                      busy16, aborted16, tail_bit16}, 7'd0);
        start = 1'b1;
        repeat (3) step();
        check_eq("start_in_reset", {busy16, word_ready16}, 2'b00);
        prog_reset = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        repeat (2) step();
        check_eq("idle_after_reset", {busy16, ccff_shift_en16}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
